// File: rtl/regfile_param.sv
// Integer register file with x0 hard-wired to zero, two combinational read ports,
// one write port, a program counter and a per-register busy scoreboard.
module regfile_param #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      ADDR_W   = 5,
   parameter int unsigned      PC_INC   = 4,
   parameter logic [XLEN-1:0]  PC_RESET = '0,
   parameter bit               BYPASS   = 1'b1
) (
   input  logic              CK_REF,
   input  logic              RST_N,
   input  logic              HALT,
   input  logic [ADDR_W-1:0] RS1_ADDR,
   input  logic [ADDR_W-1:0] RS2_ADDR,
   output logic [XLEN-1:0]   RS1_DATA,
   output logic [XLEN-1:0]   RS2_DATA,
   output logic              RS1_BUSY,
   output logic              RS2_BUSY,
   input  logic              WE,
   input  logic [ADDR_W-1:0] RD_ADDR,
   input  logic [XLEN-1:0]   WDATA,
   input  logic              RSV_EN,
   input  logic [ADDR_W-1:0] RSV_ADDR,
   input  logic              PC_LOAD,
   input  logic [XLEN-1:0]   PC_LOAD_VAL,
   input  logic              PC_FREEZE,
   output logic [XLEN-1:0]   PC
);

   localparam int unsigned     NREG    = 2 ** ADDR_W;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            wr_ok;
   logic            hit1;
   logic            hit2;

   assign wr_ok = WE && !HALT && (RD_ADDR != '0);
   assign hit1  = BYPASS && wr_ok && (RD_ADDR == RS1_ADDR);
   assign hit2  = BYPASS && wr_ok && (RD_ADDR == RS2_ADDR);

   // Clear before set so a same-cycle reserve of the written register keeps it busy.
   always_comb begin
      busy_next = busy;
      if (WE) busy_next[RD_ADDR] = 1'b0;
      if (RSV_EN && (RSV_ADDR != '0)) busy_next[RSV_ADDR] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge CK_REF or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
         busy <= '0;
         PC   <= PC_RESET;
      end else if (!HALT) begin
         if (wr_ok) regs[RD_ADDR] <= WDATA;
         busy <= busy_next;
         if (PC_LOAD)         PC <= PC_LOAD_VAL;
         else if (!PC_FREEZE) PC <= PC + PC_STEP;
      end
   end

   always_comb begin
      RS1_DATA = hit1 ? WDATA : regs[RS1_ADDR];
      RS2_DATA = hit2 ? WDATA : regs[RS2_ADDR];
      RS1_BUSY = hit1 ? 1'b0 : busy[RS1_ADDR];
      RS2_BUSY = hit2 ? 1'b0 : busy[RS2_ADDR];
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file for the RISC-V core: `2**ADDR_W` architectural registers with x0 hard-wired to zero, two asynchronous read ports, and one synchronous write port. It also holds a dedicated program counter with a configurable increment, load and freeze, a per-register busy scoreboard for hazard detection, and optional same-cycle write-to-read bypass. It sits between the decode stage (reads, reserve), the writeback stage (writes) and the fetch stage (PC).

## Interface
- XLEN, 32, data and PC width in bits
- ADDR_W, 5, register address width; register count is `2**ADDR_W`
- PC_INC, 4, amount added to the PC each advancing cycle
- PC_RESET, 0, PC value after reset
- BYPASS, 1, 1 = forward same-cycle write data to the read ports; 0 = no forwarding
- CK_REF  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- HALT  in  1  freezes all state: registers, PC and scoreboard
- RS1_ADDR, RS2_ADDR  in  ADDR_W  read port addresses
- RS1_DATA, RS2_DATA  out  XLEN  read data
- RS1_BUSY, RS2_BUSY  out  1  the addressed register has a pending write
- WE  in  1  write enable for the writeback stage
- RD_ADDR  in  ADDR_W  write address
- WDATA  in  XLEN  write data
- RSV_EN  in  1  reserve (mark busy) register RSV_ADDR; issued by decode
- RSV_ADDR  in  ADDR_W  register to reserve
- PC_LOAD  in  1  load PC_LOAD_VAL into the PC (jump or branch taken)
- PC_LOAD_VAL  in  XLEN  new PC value
- PC_FREEZE  in  1  hold the PC (stall)
- PC  out  XLEN  current PC

## Operation
- **Reset (RST_N low, async):**
  - All registers = 0.
  - PC = PC_RESET.
  - All busy bits = 0.
  - Outputs after reset: RSx_DATA = 0, RSx_BUSY = 0, PC = PC_RESET.
- **Write:**
  - On a rising edge with WE=1, HALT=0 and RD_ADDR≠0: reg[RD_ADDR] ← WDATA.
  - Writes to x0 are discarded; x0 always reads 0.
- **Read:**
  - Combinational. RSx_DATA = reg[RSx_ADDR].
  - If BYPASS=1, WE=1, HALT=0, RD_ADDR≠0 and RD_ADDR==RSx_ADDR, then RSx_DATA = WDATA instead.
  - Both ports may address the same register.
- **PC update, priority order:**
  1. HALT: hold.
  2. PC_LOAD: PC ← PC_LOAD_VAL.
  3. PC_FREEZE: hold.
  4. Otherwise: PC ← PC + PC_INC, modulo `2**XLEN` (wraps silently).
  - PC_LOAD overrides PC_FREEZE.
- **Scoreboard (one busy bit per register; bit 0 is constant 0):**
  - On an edge with HALT=0:
    - WE=1 clears busy[RD_ADDR].
    - RSV_EN=1 sets busy[RSV_ADDR].
  - If both hit the same register in one cycle, set wins: the new producer is in flight.
  - RSV_ADDR=0 is ignored.
- **Busy outputs:**
  - RSx_BUSY = busy[RSx_ADDR].
  - If BYPASS=1 and a bypass hit is active on that port, RSx_BUSY = 0, because the data is valid this cycle.
  - If BYPASS=0, busy is reported until the edge that writes the register.
- HALT=1 blocks writes, reservations and PC changes. Read ports remain live; bypass is suppressed during HALT.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write becomes visible:
  - BYPASS=1: same cycle.
  - BYPASS=0: the cycle after the write edge.
- PC load/increment takes effect at the next rising edge; PC is a registered output.
- Reserve: the busy bit is visible on RSx_BUSY the cycle after the RSV_EN edge.
- Clear: busy drops at the write edge; with BYPASS=1 it already reads 0 during the write cycle.
- Reset asserted mid-operation: all state clears immediately (async). The first PC increment occurs at the first rising edge after RST_N deasserts.

## Test plan
- **Reset:**
  - Stimulus: assert RST_N mid-run with reg x5=0x1234 and busy[5]=1.
  - Required response: immediately x5 reads 0, RS1_BUSY=0, PC=PC_RESET (0).
- **Write, read and x0:**
  - Stimulus: write 0xDEADBEEF to x7, then 0xFFFFFFFF to x0.
  - Required response: RS1=x7 reads 0xDEADBEEF next cycle; RS2=x0 reads 0 throughout.
- **Bypass:**
  - Stimulus, BYPASS=1: WE=1, RD=x3, WDATA=0xA5, RS1=RS2=x3 in the same cycle.
  - Required response: both ports show 0xA5 that cycle.
  - Stimulus, BYPASS=0: same inputs.
  - Required response: old value that cycle, 0xA5 the next.
- **PC:**
  - PC=0xFFFFFFFC with PC_INC=4: next PC = 0x00000000.
  - PC_LOAD=1 and PC_FREEZE=1 with PC_LOAD_VAL=0x100: PC = 0x100.
  - PC_FREEZE alone: PC held.
  - HALT=1 with PC_LOAD=1: PC held.
- **Scoreboard:**
  - RSV_EN on x9: RS1_BUSY(x9)=1 next cycle.
  - WE=1 and RSV_EN=1 on x9 in the same cycle: busy stays 1.
  - A later WE on x9 alone: busy=0; with BYPASS=1, RS1_BUSY=0 already in the write cycle.
- **HALT:**
  - Stimulus: HALT=1 with WE, RSV_EN and PC increment all active for 3 cycles.
  - Required response: no register, busy or PC change. Resumes on the first edge after HALT=0.
